// File: rtl/nic_pe_iface_pkg.sv
// Shared constants for the PE network interface: flit width, VC bit position,
// processor register map and packet counter geometry.
package nic_pe_iface_pkg;

    localparam int unsigned FLIT_W     = 64;
    localparam int unsigned PKT_VC_BIT = 63;
    localparam int unsigned ADDR_W     = 2;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned CNT_LSB    = 32;

    localparam logic [ADDR_W-1:0] NIC_ADDR_IN_DATA  = 2'b00;
    localparam logic [ADDR_W-1:0] NIC_ADDR_IN_STAT  = 2'b01;
    localparam logic [ADDR_W-1:0] NIC_ADDR_OUT_DATA = 2'b10;
    localparam logic [ADDR_W-1:0] NIC_ADDR_OUT_STAT = 2'b11;

endpackage

// File: rtl/nic_chan_reg.sv
// Single-entry flit register with full flag; load wins over clear, although
// the parent never asserts both in one cycle.
module nic_chan_reg
    import nic_pe_iface_pkg::*;
#(
    parameter int unsigned DATA_W = FLIT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_clear,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full
);

    logic [DATA_W-1:0] r_data;
    logic              r_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= '0;
            r_full <= 1'b0;
        end else if (i_load) begin
            r_data <= i_data;
            r_full <= 1'b1;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end
    end

    assign o_data = r_data;
    assign o_full = r_full;

endmodule

// File: rtl/nic_pe_iface.sv
// PE network interface: one injection and one ejection flit register between
// the processor and the router PE port. Optional NIC_PKT_CNT_EN adds tx/rx counters.
module nic_pe_iface
    import nic_pe_iface_pkg::*;
#(
    parameter int unsigned DATA_W = FLIT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] d_out,
    input  logic              nicEn,
    input  logic              nicWrEn,
    output logic              net_so,
    input  logic              net_ro,
    output logic [DATA_W-1:0] net_do,
    input  logic              net_si,
    output logic              net_ri,
    input  logic [DATA_W-1:0] net_di,
    input  logic              net_polarity
);

    localparam int unsigned VC_BIT = DATA_W - 1;

    logic              w_rd;
    logic              w_wr;
    logic              w_inj_load;
    logic              w_inj_xfer;
    logic              w_ej_load;
    logic              w_ej_clear;
    logic [DATA_W-1:0] w_out_buf;
    logic              w_out_full;
    logic [DATA_W-1:0] w_in_buf;
    logic              w_in_full;
    logic [CNT_W-1:0]  w_tx_cnt;
    logic [CNT_W-1:0]  w_rx_cnt;

    assign w_rd = nicEn & ~nicWrEn;
    assign w_wr = nicEn & nicWrEn;

    // A write into a full injection register is dropped, even on its drain edge.
    assign w_inj_load = w_wr & (addr == NIC_ADDR_OUT_DATA) & ~w_out_full;
    assign w_inj_xfer = net_so & net_ro;
    assign w_ej_load  = net_si & net_ri;
    assign w_ej_clear = w_rd & (addr == NIC_ADDR_IN_DATA) & w_in_full;

    nic_chan_reg #(.DATA_W(DATA_W)) u_inj (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_inj_load),
        .i_data  (d_in),
        .i_clear (w_inj_xfer),
        .o_data  (w_out_buf),
        .o_full  (w_out_full)
    );

    nic_chan_reg #(.DATA_W(DATA_W)) u_ej (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_ej_load),
        .i_data  (net_di),
        .i_clear (w_ej_clear),
        .o_data  (w_in_buf),
        .o_full  (w_in_full)
    );

    // Only send while the flit's VC plane is in its external phase.
    assign net_so = w_out_full & (w_out_buf[VC_BIT] == net_polarity);
    assign net_do = w_out_buf;
    assign net_ri = ~w_in_full;

`ifdef NIC_PKT_CNT_EN
    logic [CNT_W-1:0] r_tx_cnt;
    logic [CNT_W-1:0] r_rx_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_cnt <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (w_inj_xfer) r_tx_cnt <= r_tx_cnt + CNT_W'(1);
            if (w_ej_load)  r_rx_cnt <= r_rx_cnt + CNT_W'(1);
        end
    end

    assign w_tx_cnt = r_tx_cnt;
    assign w_rx_cnt = r_rx_cnt;
`else
    assign w_tx_cnt = '0;
    assign w_rx_cnt = '0;
`endif

    always_comb begin
        d_out = '0;
        if (w_rd) begin
            case (addr)
                NIC_ADDR_IN_DATA: d_out = w_in_buf;
                NIC_ADDR_IN_STAT: begin
                    d_out[0]                = w_in_full;
                    d_out[CNT_LSB +: CNT_W] = w_rx_cnt;
                end
                NIC_ADDR_OUT_STAT: begin
                    d_out[0]                = w_out_full;
                    d_out[CNT_LSB +: CNT_W] = w_tx_cnt;
                end
                default: d_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_nic_pe_iface.sv
// Scoreboard bench for nic_pe_iface: injected flits and ejected flits are
// queued when driven and checked when the DUT presents them.
module tb_nic_pe_iface;
    import nic_pe_iface_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  addr;
    logic [63:0] d_in;
    logic [63:0] d_out;
    logic        nicEn;
    logic        nicWrEn;
    logic        net_so;
    logic        net_ro;
    logic [63:0] net_do;
    logic        net_si;
    logic        net_ri;
    logic [63:0] net_di;
    logic        net_polarity;

    int tests_run    = 0;
    int tests_failed = 0;
    int inj_cnt      = 0;
    int ej_cnt       = 0;
    logic [63:0] inj_q[$];
    logic [63:0] ej_q[$];
    logic [63:0] v;
    logic [63:0] exp_ej;

    nic_pe_iface dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicWrEn      (nicWrEn),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di),
        .net_polarity (net_polarity)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Processor access: driven at a negedge, held across one rising edge.
    task automatic rd(input logic [1:0] a, output logic [63:0] val);
        nicEn = 1'b1; nicWrEn = 1'b0; addr = a;
        #1 val = d_out;
        @(negedge clk);
        nicEn = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [63:0] dat);
        nicEn = 1'b1; nicWrEn = 1'b1; addr = a; d_in = dat;
        @(negedge clk);
        nicEn = 1'b0; nicWrEn = 1'b0;
    endtask

    // Injection monitor: sampled mid low phase, ahead of the transfer edge.
    always @(negedge clk) begin
        #3;
        if (!reset) begin
            if (net_so && net_ro) begin
                inj_cnt++;
                chk("inj_pending", 64'(inj_q.size() != 0), 64'd1);
                if (inj_q.size() != 0) chk("inj_data", net_do, inj_q.pop_front());
            end
            if (net_si && net_ri) ej_cnt++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; addr = '0; d_in = '0; nicEn = 1'b0; nicWrEn = 1'b0;
        net_ro = 1'b0; net_si = 1'b0; net_di = '0; net_polarity = 1'b0;
        @(negedge clk); @(negedge clk);
        #1;
        chk("rst_so",   64'(net_so), 64'd0);
        chk("rst_ri",   64'(net_ri), 64'd1);
        chk("rst_do",   net_do, 64'd0);
        chk("rst_dout", d_out, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        rd(NIC_ADDR_IN_STAT, v);  chk("rst_in_stat", v, 64'd0);
        rd(NIC_ADDR_OUT_STAT, v); chk("rst_out_stat", v, 64'd0);

        // VC phase gating
        net_ro = 1'b1; net_polarity = 1'b0;
        inj_q.push_back(64'h8000_0000_0000_00AA);
        wr(NIC_ADDR_OUT_DATA, 64'h8000_0000_0000_00AA);
        repeat (3) begin
            #1 chk("vc_wait_so", 64'(net_so), 64'd0);
            @(negedge clk);
        end
        rd(NIC_ADDR_OUT_STAT, v); chk("vc_wait_stat", v, 64'd1);
        net_polarity = 1'b1;
        #1 chk("vc_so_hi", 64'(net_so), 64'd1);
        chk("vc_do", net_do, 64'h8000_0000_0000_00AA);
        @(negedge clk);
        #1 chk("vc_so_pulse", 64'(net_so), 64'd0);
        chk("vc_inj_cnt", 64'(inj_cnt), 64'd1);
        @(negedge clk);
        rd(NIC_ADDR_OUT_STAT, v); chk("vc_done_stat", v, 64'd0);

        // Write into full register is dropped
        net_polarity = 1'b0; net_ro = 1'b0;
        inj_q.push_back(64'h1);
        wr(NIC_ADDR_OUT_DATA, 64'h1);
        wr(NIC_ADDR_OUT_DATA, 64'h2);
        #1 chk("hold_so", 64'(net_so), 64'd1);
        chk("hold_do", net_do, 64'h1);
        @(negedge clk);
        net_ro = 1'b1;
        @(negedge clk);
        chk("drop_inj_cnt", 64'(inj_cnt), 64'd2);
        rd(NIC_ADDR_OUT_STAT, v); chk("drop_stat", v, 64'd0);

        // Write coinciding with the drain edge is also dropped
        net_ro = 1'b0;
        inj_q.push_back(64'h3);
        wr(NIC_ADDR_OUT_DATA, 64'h3);
        net_ro = 1'b1;
        wr(NIC_ADDR_OUT_DATA, 64'h4);
        rd(NIC_ADDR_OUT_STAT, v); chk("drain_drop_stat", v, 64'd0);
        chk("drain_inj_cnt", 64'(inj_cnt), 64'd3);
        chk("drain_q_empty", 64'(inj_q.size()), 64'd0);

        // Write-to-send latency of one cycle
        inj_q.push_back(64'h7);
        wr(NIC_ADDR_OUT_DATA, 64'h7);
        #1 chk("lat_so", 64'(net_so), 64'd1);
        @(negedge clk);
        chk("lat_inj_cnt", 64'(inj_cnt), 64'd4);

        // Ejection: second back-to-back flit refused
        ej_q.push_back(64'h55);
        net_si = 1'b1; net_di = 64'h55;
        #1 chk("ej_ri_empty", 64'(net_ri), 64'd1);
        @(negedge clk);
        #1 chk("ej_ri_full", 64'(net_ri), 64'd0);
        @(negedge clk);
        net_si = 1'b0; net_di = '0;
        chk("ej_cnt", 64'(ej_cnt), 64'd1);
        rd(NIC_ADDR_IN_STAT, v); chk("ej_stat_full", v, 64'd1);
        exp_ej = ej_q.pop_front();
        rd(NIC_ADDR_IN_DATA, v); chk("ej_data", v, exp_ej);
        #1 chk("ej_ri_back", 64'(net_ri), 64'd1);
        @(negedge clk);
        rd(NIC_ADDR_IN_DATA, v); chk("ej_stale", v, 64'h55);
        rd(NIC_ADDR_IN_STAT, v); chk("ej_stat_empty", v, 64'd0);
        rd(NIC_ADDR_OUT_DATA, v); chk("rd_out_data", v, 64'd0);
        wr(NIC_ADDR_IN_DATA, 64'hFFFF);
        wr(NIC_ADDR_OUT_STAT, 64'hFFFF);
        rd(NIC_ADDR_IN_STAT, v);  chk("wr_ign_in", v, 64'd0);
        rd(NIC_ADDR_OUT_STAT, v); chk("wr_ign_out", v, 64'd0);

        // Asynchronous reset with both registers full
        net_ro = 1'b0;
        wr(NIC_ADDR_OUT_DATA, 64'h9);
        net_si = 1'b1; net_di = 64'h77;
        @(negedge clk);
        net_si = 1'b0;
        #1 chk("pre_rst_so", 64'(net_so), 64'd1);
        chk("pre_rst_ri", 64'(net_ri), 64'd0);
        reset = 1'b1;
        #1 chk("async_so", 64'(net_so), 64'd0);
        chk("async_ri", 64'(net_ri), 64'd1);
        chk("async_do", net_do, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        rd(NIC_ADDR_IN_STAT, v);  chk("post_rst_in", v, 64'd0);
        rd(NIC_ADDR_OUT_STAT, v); chk("post_rst_out", v, 64'd0);

        // Traffic for the packet counters: three out, two in
        net_polarity = 1'b0; net_ro = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            inj_q.push_back(64'(k) + 64'h100);
            wr(NIC_ADDR_OUT_DATA, 64'(k) + 64'h100);
            @(negedge clk);
        end
        for (int k = 1; k <= 2; k++) begin
            ej_q.push_back(64'(k) + 64'h200);
            net_si = 1'b1; net_di = 64'(k) + 64'h200;
            @(negedge clk);
            net_si = 1'b0;
            exp_ej = ej_q.pop_front();
            rd(NIC_ADDR_IN_DATA, v); chk("cnt_ej_data", v, exp_ej);
        end
        chk("cnt_q_empty", 64'(inj_q.size()), 64'd0);
`ifdef NIC_PKT_CNT_EN
        rd(NIC_ADDR_OUT_STAT, v); chk("tx_cnt", v, 64'd3 << 32);
        rd(NIC_ADDR_IN_STAT, v);  chk("rx_cnt", v, 64'd2 << 32);
`else
        rd(NIC_ADDR_OUT_STAT, v); chk("tx_cnt_absent", v, 64'd0);
        rd(NIC_ADDR_IN_STAT, v);  chk("rx_cnt_absent", v, 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
